regheap_mp: RTL and testbench
=============================

// Module: regheap_mp
// PURPOSE
//  Parametrised successor to the single-write register heap: DEPTH x DATA_W register file,
//  2 combinational read ports, 2 write ports, optional hardwired-zero entry 0, write-to-read
//  bypass and a sequential clear engine that zeroes the array after reset or on request.
//  Sits in the datapath decode stage; ready gates the pipeline until the array is clean.
// PARAMETERS
//  DATA_W    32  register width in bits
//  ADDR_W    5   address width; DEPTH = 2**ADDR_W entries
//  ZERO_REG  1   1: entry 0 reads 0 and ignores writes; 0: entry 0 is an ordinary register
//  BYPASS    1   1: same-cycle write data forwarded to matching read port; 0: no forwarding
// PORTS
//  clk     in   1       rising-edge clock
//  rst_n   in   1       asynchronous reset, active low
//  clr     in   1       soft clear request (one-cycle pulse sufficient), re-runs clear sweep
//  we_a    in   1       write enable, port A
//  wreg_a  in   ADDR_W  write address, port A
//  wdata_a in   DATA_W  write data, port A
//  we_b    in   1       write enable, port B (wins over A on same address)
//  wreg_b  in   ADDR_W  write address, port B
//  wdata_b in   DATA_W  write data, port B
//  rreg1   in   ADDR_W  read address, port 1
//  rreg2   in   ADDR_W  read address, port 2
//  rdata1  out  DATA_W  read data, port 1 (combinational)
//  rdata2  out  DATA_W  read data, port 2 (combinational)
//  ready   out  1       1 = array valid, writes accepted; 0 = clear sweep in progress
// BEHAVIOUR
//  - Storage array is NOT reset directly; only FSM state, clear counter and ready are async-reset.
//  - FSM states: CLEAR, RUN. rst_n low -> state=CLEAR, cnt=0, ready=0 (async).
//  - CLEAR: each cycle writes 0 to entry cnt, cnt++; on cnt==DEPTH-1 write, -> RUN next edge.
//    Sweep takes exactly DEPTH cycles after rst_n release; ready rises on the following edge.
//  - RUN: ready=1. clr=1 sampled at edge -> CLEAR with cnt=0, ready=0 from next cycle.
//  - clr while already in CLEAR: ignored (sweep continues, not restarted).
//  - rst_n asserted mid-sweep: FSM returns to CLEAR, cnt=0, full sweep restarts.
//  - While ready=0: we_a/we_b ignored; rdata1/rdata2 forced to 0 (no bypass).
//  - RUN writes: on rising edge, we_a writes wdata_a to wreg_a, we_b writes wdata_b to wreg_b.
//    Same address both enabled: only wdata_b stored. Distinct addresses: both stored.
//  - ZERO_REG=1: writes to address 0 dropped; reads of address 0 return 0 (incl. bypass).
//  - Reads (RUN): rdataN = array[rregN], unless BYPASS=1 and a same-cycle enabled write
//    matches rregN: then returns wdata_b if B matches, else wdata_a. Zero-cycle latency.
//  - BYPASS=0: read of an address written this cycle returns old value; new value next cycle.
//  - Address arithmetic: cnt is ADDR_W+1 bits wide internally so DEPTH-1 terminal detect
//    does not wrap; all addresses unsigned, no out-of-range values exist.
// TESTING
//  1 Reset: rst_n low 3 cycles, release -> ready=0 for exactly 2**ADDR_W (32) cycles, then 1;
//    all 32 entries read 0 afterwards.
//  2 Basic write/read: we_a, wreg_a=5, wdata_a=32'hDEADBEEF -> next cycle rdata1 (rreg1=5)
//    = 32'hDEADBEEF; BYPASS=1 -> rdata1 already 32'hDEADBEEF during the write cycle.
//  3 Collision: we_a=we_b=1, both addr 7, A=32'h1111_1111, B=32'h2222_2222 -> entry 7 =
//    32'h2222_2222, bypass on rreg2=7 shows 32'h2222_2222 same cycle.
//  4 Zero reg: ZERO_REG=1, write 32'hFFFF_FFFF to addr 0 -> rdata1(rreg1=0)=0 same and next
//    cycle; ZERO_REG=0 build -> reads 32'hFFFF_FFFF next cycle.
//  5 Soft clear: fill entries 1..31 with index value, pulse clr -> ready=0 for 32 cycles,
//    writes during sweep ignored, all entries 0 after ready returns; second clr mid-sweep ignored.
//  6 Reset mid-sweep: assert rst_n at sweep cycle 10 -> ready stays 0, sweep restarts at
//    entry 0, ready=1 exactly 32 cycles after release.

Source files
------------

// File: rtl/regheap_mp.sv
// Dual-write, dual-read register heap with optional hardwired zero entry,
// write-to-read forwarding and a sequential clear sweep gating the pipeline.
module regheap_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] wreg_a,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] wreg_b,
  input  logic [DATA_W-1:0] wdata_b,
  input  logic [ADDR_W-1:0] rreg1,
  input  logic [ADDR_W-1:0] rreg2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic              ready
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(DEPTH - 1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic [DATA_W-1:0] mem [DEPTH];

  logic wr_a, wr_b;
  logic hit1_a, hit1_b, hit2_a, hit2_b;
  logic zero1, zero2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  // A clear request only matters from RUN; once sweeping, it runs to completion.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = RUN;
          ready_d = 1'b1;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (clr) begin
          state_d = CLEAR;
          cnt_d   = '0;
          ready_d = 1'b0;
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
        ready_d = 1'b0;
      end
    endcase
  end

  assign wr_a = ready_q && we_a && !((ZERO_REG != 0) && (wreg_a == '0));
  assign wr_b = ready_q && we_b && !((ZERO_REG != 0) && (wreg_b == '0));

  // Port B is written last so it wins when both ports hit the same entry.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem[cnt_q[ADDR_W-1:0]] <= '0;
    end else begin
      if (wr_a) mem[wreg_a] <= wdata_a;
      if (wr_b) mem[wreg_b] <= wdata_b;
    end
  end

  assign hit1_a = (BYPASS != 0) && wr_a && (wreg_a == rreg1);
  assign hit1_b = (BYPASS != 0) && wr_b && (wreg_b == rreg1);
  assign hit2_a = (BYPASS != 0) && wr_a && (wreg_a == rreg2);
  assign hit2_b = (BYPASS != 0) && wr_b && (wreg_b == rreg2);

  assign zero1 = !ready_q || ((ZERO_REG != 0) && (rreg1 == '0));
  assign zero2 = !ready_q || ((ZERO_REG != 0) && (rreg2 == '0));

  assign rdata1 = zero1  ? '0 :
                  hit1_b ? wdata_b :
                  hit1_a ? wdata_a : mem[rreg1];
  assign rdata2 = zero2  ? '0 :
                  hit2_b ? wdata_b :
                  hit2_a ? wdata_a : mem[rreg2];

  assign ready = ready_q;

endmodule

// File: tb/tb_regheap_mp.sv
// Directed bench for regheap_mp: one default build and one without
// the zero entry or forwarding, driven by the same stimulus.
module tb_regheap_mp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        clr = 1'b0;
  logic        we_a = 1'b0, we_b = 1'b0;
  logic [4:0]  wreg_a = '0, wreg_b = '0, rreg1 = '0, rreg2 = '0;
  logic [31:0] wdata_a = '0, wdata_b = '0;
  logic [31:0] rdata1, rdata2, rdata1_n, rdata2_n;
  logic        ready, ready_n;

  int compareCount = 0;
  int mismatchCount = 0;
  int zeros;

  always #5 clk = ~clk;

  regheap_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .we_a(we_a), .wreg_a(wreg_a), .wdata_a(wdata_a),
    .we_b(we_b), .wreg_b(wreg_b), .wdata_b(wdata_b),
    .rreg1(rreg1), .rreg2(rreg2),
    .rdata1(rdata1), .rdata2(rdata2), .ready(ready)
  );

  regheap_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0)) dutPlain (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .we_a(we_a), .wreg_a(wreg_a), .wdata_a(wdata_a),
    .we_b(we_b), .wreg_b(wreg_b), .wdata_b(wdata_b),
    .rreg1(rreg1), .rreg2(rreg2),
    .rdata1(rdata1_n), .rdata2(rdata2_n), .ready(ready_n)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic wa, input logic [4:0] ra, input logic [31:0] da,
                               input logic wb, input logic [4:0] rb, input logic [31:0] db,
                               input logic [4:0] r1, input logic [4:0] r2);
    we_a = wa; wreg_a = ra; wdata_a = da;
    we_b = wb; wreg_b = rb; wdata_b = db;
    rreg1 = r1; rreg2 = r2;
    #1;
  endtask

  // Counts cycles with ready low while hammering writes that must be ignored.
  task automatic countSweep(input int clrAgainAt, input int stopAt, output int cycles);
    cycles = 0;
    for (int k = 0; k < 80; k++) begin
      if (ready === 1'b1) break;
      cycles++;
      if (stopAt != 0 && cycles == stopAt) break;
      clr = (cycles == clrAgainAt);
      applyStimulus(1'b1, 5'd9, 32'h0000ABCD, 1'b1, 5'd12, 32'h0000CDEF, 5'd9, 5'd12);
      if (cycles == 5) begin
        checkOutput("sweep_rd1", rdata1, 32'h0);
        checkOutput("sweep_rd2_plain", rdata2_n, 32'h0);
      end
      @(negedge clk); #1;
    end
    clr = 1'b0;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
  endtask

  task automatic checkAllZero(input string tag);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
      checkOutput(tag, rdata1, 32'h0);
      checkOutput({tag, "_plain"}, rdata2_n, 32'h0);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Power-on reset and initial sweep
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    checkOutput("reset_ready", 32'(ready), 32'h0);
    checkOutput("reset_ready_plain", 32'(ready_n), 32'h0);
    rst_n = 1'b1;
    #1;
    countSweep(0, 0, zeros);
    checkOutput("init_sweep_len", 32'(zeros), 32'd32);
    checkOutput("init_ready_plain", 32'(ready_n), 32'h1);
    checkAllZero("init_zero");

    // Basic write with forwarding
    @(negedge clk);
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
    checkOutput("wr_bypass", rdata1, 32'hDEADBEEF);
    checkOutput("wr_nobypass_old", rdata1_n, 32'h0);
    @(negedge clk);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
    checkOutput("wr_next", rdata1, 32'hDEADBEEF);
    checkOutput("wr_next_plain", rdata1_n, 32'hDEADBEEF);

    // Same-address collision: B wins
    @(negedge clk);
    applyStimulus(1'b1, 5'd7, 32'h11111111, 1'b1, 5'd7, 32'h22222222, 5'd5, 5'd7);
    checkOutput("coll_bypass", rdata2, 32'h22222222);
    checkOutput("coll_nobypass_old", rdata2_n, 32'h0);
    @(negedge clk);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
    checkOutput("coll_stored", rdata1, 32'h22222222);
    checkOutput("coll_stored_plain", rdata2_n, 32'h22222222);

    // Distinct addresses both stored; A forwarded alone
    @(negedge clk);
    applyStimulus(1'b1, 5'd3, 32'h00000033, 1'b1, 5'd4, 32'h00000044, 5'd3, 5'd4);
    checkOutput("dual_bypass_a", rdata1, 32'h00000033);
    checkOutput("dual_bypass_b", rdata2, 32'h00000044);
    @(negedge clk);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd4);
    checkOutput("dual_a", rdata1_n, 32'h00000033);
    checkOutput("dual_b", rdata2_n, 32'h00000044);

    // Entry 0: hardwired zero vs ordinary register
    @(negedge clk);
    applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    checkOutput("zero_same", rdata1, 32'h0);
    checkOutput("zero_same_plain", rdata1_n, 32'h0);
    @(negedge clk);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    checkOutput("zero_next", rdata1, 32'h0);
    checkOutput("zero_next_plain", rdata1_n, 32'hFFFFFFFF);

    // Fill 1..31 with index, then soft clear with a second request mid-sweep
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      applyStimulus(1'b1, 5'(i), 32'(i), 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    end
    @(negedge clk);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd31);
    checkOutput("fill_9", rdata1, 32'd9);
    checkOutput("fill_31_plain", rdata2_n, 32'd31);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    #1;
    countSweep(10, 0, zeros);
    checkOutput("clr_sweep_len", 32'(zeros), 32'd32);
    checkAllZero("clr_zero");

    // Reset during a sweep restarts it from entry 0
    @(negedge clk);
    applyStimulus(1'b1, 5'd2, 32'h0BADF00D, 1'b1, 5'd20, 32'hCAFEF00D, 5'd0, 5'd0);
    @(negedge clk);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd2, 5'd20);
    checkOutput("pre_rst_2", rdata1, 32'h0BADF00D);
    checkOutput("pre_rst_20", rdata2, 32'hCAFEF00D);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    #1;
    countSweep(0, 10, zeros);
    checkOutput("mid_sweep_reached", 32'(zeros), 32'd10);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_ready", 32'(ready), 32'h0);
    repeat (2) @(negedge clk);
    #1;
    checkOutput("mid_rst_hold", 32'(ready_n), 32'h0);
    rst_n = 1'b1;
    #1;
    countSweep(0, 0, zeros);
    checkOutput("rst_sweep_len", 32'(zeros), 32'd32);
    @(negedge clk);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd2, 5'd20);
    checkOutput("post_rst_2", rdata1, 32'h0);
    checkOutput("post_rst_20_plain", rdata2_n, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
